// File: rtl/countdown_timer_of_timer_if.sv
// countdown_timer_of_timer_if
//   Host-side bundle for the cascaded countdown timer.
//   master : host (drives load/load_value/start/pause, observes status)
//   slave  : timer block (observes requests, drives timer/control_counter/busy/done)
//   Signals:
//     load, load_value[CTRL_W] : load request and unit count
//     start, pause             : run control (levels sampled per clock)
//     timer[TIMER_W]           : inner countdown value
//     control_counter[CTRL_W]  : remaining outer units
//     busy, done               : status and one-cycle expiry pulse
interface countdown_timer_of_timer_if #(
  parameter int TIMER_W = 4,
  parameter int CTRL_W  = 7
);
  logic              load;
  logic [CTRL_W-1:0] load_value;
  logic              start;
  logic              pause;
  logic [TIMER_W-1:0] timer;
  logic [CTRL_W-1:0] control_counter;
  logic              busy;
  logic              done;

  modport master (
    output load, load_value, start, pause,
    input  timer, control_counter, busy, done
  );

  modport slave (
    input  load, load_value, start, pause,
    output timer, control_counter, busy, done
  );
endinterface

// File: rtl/countdown_timer_of_timer.sv
// countdown_timer_of_timer
//   Cascaded down-counter. The inner timer runs TIMER_MAX..0 repeatedly and the
//   outer control_counter drops by one on every inner wrap. A load of N gives
//   N*(TIMER_MAX+1) counting cycles, followed by a one-cycle done pulse.
//   Ports:
//     clk   : system clock, rising edge
//     reset : asynchronous, active-high
//     bus   : countdown_timer_of_timer_if.slave (load/start/pause in,
//             timer/control_counter/busy/done out); all outputs registered
//   Optional feature (macro COUNTDOWN_AUTO_RELOAD_EN):
//     DONE reloads from the loaded value and keeps running (periodic done),
//     and start while busy stops the count back to IDLE with counters held.
//   TIMER_MAX must fit in TIMER_W bits.
module countdown_timer_of_timer #(
  parameter int TIMER_W   = 4,
  parameter int CTRL_W    = 7,
  parameter int TIMER_MAX = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  countdown_timer_of_timer_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(TIMER_MAX);
  localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1);
  localparam logic [CTRL_W-1:0]  CTRL_ONE     = CTRL_W'(1);

  logic [1:0]         state_reg, state_next;
  logic [TIMER_W-1:0] timer_reg, timer_next;
  logic [CTRL_W-1:0]  ctrl_reg, ctrl_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  // Loaded unit count, only needed to restart the count after DONE.
  logic [CTRL_W-1:0]  loaded_reg, loaded_next;
`endif

  // One counting step, shared by RUN and by the PAUSE->RUN release cycle so
  // that every pause cycle costs exactly one cycle of expiry time.
  logic [1:0]         step_state;
  logic [TIMER_W-1:0] step_timer;
  logic [CTRL_W-1:0]  step_ctrl;
  logic               step_busy;
  logic               step_done;

  always_comb begin
    step_state = RUN;
    step_timer = timer_reg;
    step_ctrl  = ctrl_reg;
    step_busy  = 1'b1;
    step_done  = 1'b0;
    if (timer_reg != '0) begin
      step_timer = timer_reg - TIMER_ONE;
    end else if (ctrl_reg > CTRL_ONE) begin
      step_ctrl  = ctrl_reg - CTRL_ONE;
      step_timer = TIMER_RELOAD;
    end else begin
      // Last unit exhausted: timer stays at 0, control counter clears.
      step_ctrl  = '0;
      step_state = DONE;
      step_busy  = 1'b0;
      step_done  = 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    ctrl_next  = ctrl_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    loaded_next = loaded_reg;
`endif
    case (state_reg)
      IDLE: begin
        busy_next = 1'b0;
        if (bus.load) begin
          // Load wins over a simultaneous start.
          ctrl_next  = bus.load_value;
          timer_next = TIMER_RELOAD;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          loaded_next = bus.load_value;
`endif
        end else if (bus.start) begin
          if (ctrl_reg != '0) begin
            state_next = RUN;
            busy_next  = 1'b1;
          end else if (!done_reg) begin
            // Nothing to count: expire immediately. Gating on done_reg keeps
            // a held start from producing back-to-back done cycles.
            done_next = 1'b1;
          end
        end
      end

      RUN: begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        if (bus.start) begin
          state_next = IDLE;
          busy_next  = 1'b0;
        end else
`endif
        if (bus.pause) begin
          state_next = PAUSE;
        end else begin
          state_next = step_state;
          timer_next = step_timer;
          ctrl_next  = step_ctrl;
          busy_next  = step_busy;
          done_next  = step_done;
        end
      end

      PAUSE: begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        if (bus.start) begin
          state_next = IDLE;
          busy_next  = 1'b0;
        end else
`endif
        if (!bus.pause) begin
          state_next = step_state;
          timer_next = step_timer;
          ctrl_next  = step_ctrl;
          busy_next  = step_busy;
          done_next  = step_done;
        end
      end

      default: begin // DONE
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        state_next = RUN;
        ctrl_next  = loaded_reg;
        timer_next = TIMER_RELOAD;
        busy_next  = 1'b1;
`else
        state_next = IDLE;
        busy_next  = 1'b0;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      timer_reg <= '0;
      ctrl_reg  <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      loaded_reg <= '0;
`endif
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      ctrl_reg  <= ctrl_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      loaded_reg <= loaded_next;
`endif
    end
  end

  assign bus.timer           = timer_reg;
  assign bus.control_counter = ctrl_reg;
  assign bus.busy            = busy_reg;
  assign bus.done            = done_reg;

endmodule
